// File: rtl/care_cmd_decoder.sv
// Decodes 3-byte care frames (A5, CMD, CMD^5A) into one-hot action pulses and ACK/NAK bytes.
// Latency: action pulse and ack_valid appear the cycle after the SUM byte strobe.
// Backpressure: ack is held until ack_ready; rx bytes arriving while an ack is pending are dropped (sticky rx_overrun).
module care_cmd_decoder #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
  parameter logic [3:0]  COOLDOWN       = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       tick,
  output logic [5:0] action,
  output logic [7:0] ack_data,
  output logic       ack_valid,
  input  logic       ack_ready,
  output logic       busy,
  output logic       rx_overrun
);

  localparam logic [7:0] HDR_BYTE = 8'hA5;
  localparam logic [7:0] SUM_KEY  = 8'h5A;
  localparam logic [7:0] NAK_SUM  = 8'h15;
  localparam logic [7:0] NAK_CMD  = 8'h16;
  localparam logic [7:0] NAK_COOL = 8'h17;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_CMD = 2'd1,
    S_SUM = 2'd2,
    S_ACK = 2'd3
  } state_t;

  state_t      state;
  logic [7:0]  cmd;
  logic [23:0] to_cnt;
  logic [3:0]  cooldown [6];

  logic [5:0]  cmd_hot;
  logic        cmd_ok;
  logic        sum_ok;
  logic        cool_busy;
  logic        accept;
  logic [7:0]  resp;
  logic        sum_strobe;
  logic [5:0]  load;
  logic        to_expire;

  // Frame evaluation: decode the latched CMD against the SUM byte currently on rx_data.
  always_comb begin
    cmd_hot   = '0;
    cool_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_hot[i] = (cmd == 8'(i + 1));
    end
    for (int i = 0; i < 6; i++) begin
      if (cmd_hot[i] && (cooldown[i] != 4'd0)) begin
        cool_busy = 1'b1;
      end
    end
    cmd_ok = |cmd_hot;
    sum_ok = (rx_data == (cmd ^ SUM_KEY));
    accept = 1'b0;
    if (!sum_ok) begin
      resp = NAK_SUM;
    end else if (!cmd_ok) begin
      resp = NAK_CMD;
    end else if (cool_busy) begin
      resp = NAK_COOL;
    end else begin
      resp   = {5'b10000, cmd[2:0]};
      accept = 1'b1;
    end
    sum_strobe = (state == S_SUM) && rx_valid;
    load       = (sum_strobe && accept) ? cmd_hot : 6'd0;
    to_expire  = (to_cnt == (TIMEOUT_CYCLES - 24'd1));
  end

  // Frame FSM with registered action/ack/busy outputs and inter-byte timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_HDR;
      cmd        <= 8'h00;
      to_cnt     <= 24'd0;
      action     <= 6'd0;
      ack_data   <= 8'h00;
      ack_valid  <= 1'b0;
      busy       <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      action <= 6'd0;
      case (state)
        S_HDR: begin
          to_cnt <= 24'd0;
          if (rx_valid && (rx_data == HDR_BYTE)) begin
            state <= S_CMD;
            busy  <= 1'b1;
          end
        end
        S_CMD: begin
          if (rx_valid) begin
            // 0xA5 here is taken as a command byte; the frame never resyncs mid-way.
            cmd    <= rx_data;
            to_cnt <= 24'd0;
            state  <= S_SUM;
          end else if (to_expire) begin
            to_cnt <= 24'd0;
            state  <= S_HDR;
            busy   <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 24'd1;
          end
        end
        S_SUM: begin
          if (rx_valid) begin
            to_cnt    <= 24'd0;
            ack_data  <= resp;
            ack_valid <= 1'b1;
            action    <= load;
            state     <= S_ACK;
          end else if (to_expire) begin
            to_cnt <= 24'd0;
            state  <= S_HDR;
            busy   <= 1'b0;
          end else begin
            to_cnt <= to_cnt + 24'd1;
          end
        end
        S_ACK: begin
          to_cnt <= 24'd0;
          if (rx_valid) begin
            rx_overrun <= 1'b1;
          end
          if (ack_ready) begin
            ack_valid <= 1'b0;
            state     <= S_HDR;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= S_HDR;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Per-action cooldown counters; a load on acceptance overrides a coincident tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 6; i++) begin
        cooldown[i] <= 4'd0;
      end
    end else begin
      for (int i = 0; i < 6; i++) begin
        if (load[i]) begin
          cooldown[i] <= COOLDOWN;
        end else if (tick && (cooldown[i] != 4'd0)) begin
          cooldown[i] <= cooldown[i] - 4'd1;
        end
      end
    end
  end

  // Output protocol properties.
  a_action_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(action));
  a_ack_hold: assert property (@(posedge clk) disable iff (reset)
                               (ack_valid && !ack_ready) |=> (ack_valid && $stable(ack_data)));

endmodule

// File: tb/tb_care_cmd_decoder.sv
// Directed bench for care_cmd_decoder with a queue-based scoreboard.
// Expected ack byte and action pulse are queued per frame; a negedge monitor checks them.
// Covers reset, cooldown, error NAKs, timeout, backpressure/overrun and resync.
module tb_care_cmd_decoder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tick;
  logic [5:0] action;
  logic [7:0] ack_data;
  logic       ack_valid;
  logic       ack_ready;
  logic       busy;
  logic       rx_overrun;

  typedef struct packed {
    logic [7:0] data;
    logic [5:0] act;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] held_data  = 8'h00;

  care_cmd_decoder #(
    .TIMEOUT_CYCLES(24'd16),
    .COOLDOWN      (4'd3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tick      (tick),
    .action    (action),
    .ack_data  (ack_data),
    .ack_valid (ack_valid),
    .ack_ready (ack_ready),
    .busy      (busy),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  // Monitor: pop on each ack_valid rise, check hold stability and stray pulses.
  always @(negedge clk) begin
    if (!reset) begin
      if (ack_valid && !prev_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got data %02h action %06b, none expected", ack_data, action);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (ack_data !== e.data) begin
            errors++;
            $display("FAIL ack_data: got %02h expected %02h", ack_data, e.data);
          end
          checks++;
          if (action !== e.act) begin
            errors++;
            $display("FAIL action: got %06b expected %06b", action, e.act);
          end
        end
      end else begin
        if (action !== 6'd0) begin
          checks++;
          errors++;
          $display("FAIL stray_action: got %06b expected 000000", action);
        end
        if (ack_valid && prev_valid) begin
          checks++;
          if (ack_data !== held_data) begin
            errors++;
            $display("FAIL ack_hold: got %02h expected %02h", ack_data, held_data);
          end
        end
      end
    end
    prev_valid = ack_valid;
    held_data  = ack_data;
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic t);
    rx_data  = b;
    rx_valid = 1'b1;
    tick     = t;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    tick     = 1'b0;
  endtask

  task automatic pulse_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      @(posedge clk);
      #1;
      tick = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (!busy && !ack_valid) done = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout: busy %0d ack_valid %0d, required both 0", busy, ack_valid);
    end
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] s,
                            input logic [7:0] ed, input logic [5:0] ea, input logic tick_on_sum);
    exp_t e;
    e.data = ed;
    e.act  = ea;
    exp_q.push_back(e);
    send_byte(8'hA5, 1'b0);
    send_byte(c, 1'b0);
    send_byte(s, tick_on_sum);
    wait_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    tick      = 1'b0;
    ack_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_action", {2'b00, action}, 8'h00);
    chk("rst_ack_valid", {7'd0, ack_valid}, 8'h00);
    chk("rst_ack_data", ack_data, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_overrun", {7'd0, rx_overrun}, 8'h00);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // First feed with explicit cycle timing.
    exp_q.push_back({8'h81, 6'b000001});
    send_byte(8'hA5, 1'b0);
    chk("busy_after_hdr", {7'd0, busy}, 8'h01);
    send_byte(8'h01, 1'b0);
    send_byte(8'h5B, 1'b0);
    chk("ack_valid_n1", {7'd0, ack_valid}, 8'h01);
    @(posedge clk);
    #1;
    chk("ack_valid_n2", {7'd0, ack_valid}, 8'h00);
    chk("busy_n2", {7'd0, busy}, 8'h00);

    // Cooldown behaviour.
    send_frame(8'h01, 8'h5B, 8'h17, 6'd0, 1'b0);
    pulse_ticks(3);
    send_frame(8'h01, 8'h5B, 8'h81, 6'b000001, 1'b1);
    pulse_ticks(2);
    send_frame(8'h01, 8'h5B, 8'h17, 6'd0, 1'b0);
    pulse_ticks(1);
    send_frame(8'h01, 8'h5B, 8'h81, 6'b000001, 1'b0);

    // Error frames and priority.
    send_frame(8'h02, 8'h00, 8'h15, 6'd0, 1'b0);
    send_frame(8'h07, 8'h5D, 8'h16, 6'd0, 1'b0);
    send_frame(8'h00, 8'h5A, 8'h16, 6'd0, 1'b0);
    send_frame(8'h02, 8'h58, 8'h82, 6'b000010, 1'b0);
    send_frame(8'h01, 8'h00, 8'h15, 6'd0, 1'b0);

    // Timeout boundary.
    send_byte(8'hA5, 1'b0);
    repeat (15) @(posedge clk);
    #1;
    chk("busy_before_timeout", {7'd0, busy}, 8'h01);
    @(posedge clk);
    #1;
    chk("busy_after_timeout", {7'd0, busy}, 8'h00);
    send_byte(8'h03, 1'b0);
    send_byte(8'h59, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("orphan_bytes_ignored", {7'd0, busy}, 8'h00);
    send_frame(8'h03, 8'h59, 8'h83, 6'b000100, 1'b0);

    // Slow frame with gaps just under the timeout.
    exp_q.push_back({8'h85, 6'b010000});
    send_byte(8'hA5, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    send_byte(8'h05, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    send_byte(8'h5F, 1'b0);
    wait_idle();

    // Backpressure and overrun.
    ack_ready = 1'b0;
    exp_q.push_back({8'h86, 6'b100000});
    send_byte(8'hA5, 1'b0);
    send_byte(8'h06, 1'b0);
    send_byte(8'h5C, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    send_byte(8'hA5, 1'b0);
    repeat (39) @(posedge clk);
    #1;
    chk("bp_ack_valid", {7'd0, ack_valid}, 8'h01);
    chk("bp_ack_data", ack_data, 8'h86);
    chk("bp_overrun", {7'd0, rx_overrun}, 8'h01);
    ack_ready = 1'b1;
    wait_idle();
    send_byte(8'h06, 1'b0);
    send_byte(8'h5C, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("dropped_not_decoded", {7'd0, busy}, 8'h00);
    chk("overrun_sticky", {7'd0, rx_overrun}, 8'h01);

    // Resync past a leading junk byte.
    send_byte(8'h55, 1'b0);
    send_frame(8'h04, 8'h5E, 8'h84, 6'b001000, 1'b0);

    // Reset while in S_SUM with feed still cooling down.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h01, 1'b0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst2_busy", {7'd0, busy}, 8'h00);
    chk("rst2_ack_valid", {7'd0, ack_valid}, 8'h00);
    chk("rst2_overrun", {7'd0, rx_overrun}, 8'h00);
    reset = 1'b0;
    @(posedge clk);
    #1;
    send_frame(8'h01, 8'h5B, 8'h81, 6'b000001, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/care_cmd_decoder.md
# care_cmd_decoder

Framed command decoder between the UART receiver and the stats block. It parses 3-byte care-command frames from the received byte stream, validates them, and enforces a per-action cooldown measured in one-second ticks. For each frame it emits a one-cycle one-hot action pulse toward stats and an ACK/NAK byte toward the UART transmitter over a valid/ready handshake.

## Interface
Parameters:
- TIMEOUT_CYCLES, 24'd10_000_000, max clk cycles allowed between bytes of one frame
- COOLDOWN, 4'd3, ticks an action stays locked after acceptance; 0 disables cooldown

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  received byte, valid only while rx_valid=1
- rx_valid  in  1  one-cycle strobe per received byte
- tick  in  1  one-cycle one-second pulse (same source as stats `second`)
- action  out  6  one-hot action pulse: bit0 feed, bit1 play, bit2 heal, bit3 clean, bit4 sleep, bit5 talk
- ack_data  out  8  response byte, stable while ack_valid=1
- ack_valid  out  1  response pending
- ack_ready  in  1  transmitter accepts ack_data when ack_valid & ack_ready
- busy  out  1  high in any state other than S_HDR
- rx_overrun  out  1  sticky; set when a byte is dropped in S_ACK

## Operation
- Frame: 0xA5, CMD, SUM, with SUM = CMD ^ 0x5A. Valid CMD = 0x01..0x06, mapped to action bit CMD-1.
- FSM states: S_HDR, S_CMD, S_SUM, S_ACK.
  - S_HDR: rx_valid with 0xA5 -> S_CMD. Any other byte is ignored.
  - S_CMD: rx_valid -> latch CMD, go to S_SUM. 0xA5 is accepted as a CMD byte; there is no resync.
  - S_SUM: rx_valid -> evaluate the frame, go to S_ACK.
  - S_ACK: hold ack_valid. On ack_valid & ack_ready -> S_HDR.
- Evaluation priority, first match wins:
  - SUM mismatch -> NAK 0x15
  - CMD outside 0x01..0x06 -> NAK 0x16
  - cooldown[CMD-1] != 0 -> NAK 0x17
  - otherwise -> ACK {5'b10000, CMD[2:0]} (0x81..0x86), pulse action[CMD-1], and load cooldown[CMD-1] = COOLDOWN.
- NAK responses never pulse action and never touch any cooldown.
- Cooldown: six 4-bit counters. Each counter decrements on tick when nonzero and saturates at 0. If a load and a tick hit the same counter in the same cycle, the load wins.
- Timeout: a 24-bit counter runs in S_CMD and S_SUM.
  - It clears to 0 on entry and on every rx_valid.
  - When it reaches TIMEOUT_CYCLES-1 with no rx_valid, the FSM returns to S_HDR silently: no ack, no action.
  - The counter is held at 0 in S_HDR and S_ACK.
- Any rx_valid during S_ACK is dropped and sets rx_overrun. rx_overrun clears only on reset.
- Reset values: state S_HDR, action 0, ack_valid 0, ack_data 0x00, busy 0, rx_overrun 0, all cooldowns 0, timeout counter 0.
- Reset mid-frame or mid-ack aborts the frame. A pending ack is discarded.

## Timing
- SUM byte strobed in cycle N:
  - action[k] is high in cycle N+1 only (registered output).
  - ack_valid rises in N+1 with ack_data valid.
  - The cooldown load is visible in N+1.
- ack_valid stays high and ack_data stays stable until the handshake cycle. ack_valid falls the cycle after the handshake, and the FSM is then in S_HDR, ready for a header byte that same cycle.
- If ack_ready is already high when ack_valid rises, the handshake completes in N+1 and ack_valid is low in N+2.
- busy is registered from state: high from the cycle after the 0xA5 strobe until the cycle after the handshake.
- Back-to-back frames need no idle cycles apart from the S_ACK handshake.

## Test plan
- Reset state: assert reset for 2 cycles -> all outputs 0, busy 0. Then send A5 01 5B -> action=6'b000001 for exactly one cycle, ack_data=0x81, ack_valid held until ack_ready.
- Cooldown: with COOLDOWN=3, send feed, ack, then feed again immediately -> NAK 0x17, no pulse. Apply 3 ticks, send feed -> ACK 0x81 with pulse. Apply a tick in the same cycle as the load -> counter reads 3.
- Errors: A5 02 00 -> 0x15. A5 07 5D -> 0x16. A5 00 5A -> 0x16. None of these pulse action or change any cooldown.
- Timeout: with TIMEOUT_CYCLES=16, send A5 then wait 16 cycles -> busy drops, no ack. A following 03 59 is ignored; a full frame A5 03 59 then yields 0x83.
- Backpressure: hold ack_ready=0 for 50 cycles after a valid frame -> ack_data stable, ack_valid high. A byte sent during that window sets rx_overrun=1 and is not decoded.
- Resync and reset: 55 A5 04 5E -> 0x84 (leading 55 ignored). Assert reset during S_SUM -> S_HDR, no action, cooldowns cleared.
